// File: rtl/piso_shift_register_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, MSB-first shift-out gated by en.
// Optional even-parity trailer bit when PARITY_EN is defined (frame becomes WIDTH+1 bits).
module piso_shift_register_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

`ifdef PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [FLEN-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [FLEN-1:0] word;
  logic            last;
  logic            accept;

`ifdef PARITY_EN
  // Parity is fixed at accept so later data_in changes cannot disturb it.
  assign word = {data_in, ^data_in};
`else
  assign word = data_in;
`endif

  assign last       = (cnt == CW'(FLEN));
  assign done       = (state == SHIFT) && last && en;
  assign load_ready = (state == IDLE) || done;
  assign accept     = load_valid && load_ready;

  assign ser_out    = sr[FLEN-1];
  assign ser_valid  = (state == SHIFT);
  assign busy       = (state == SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (accept) begin
      // Covers both the idle start and the gapless restart on the done cycle.
      state <= SHIFT;
      sr    <= word;
      cnt   <= CW'(1);
    end else if (state == SHIFT && en) begin
      if (last) begin
        state <= IDLE;
        sr    <= '0;
        cnt   <= '0;
      end else begin
        sr    <= {sr[FLEN-2:0], 1'b0};
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_register_tx.sv
// Directed bench for piso_shift_register_tx (WIDTH = 8); parity vectors apply when PARITY_EN is defined.
module tb_piso_shift_register_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] data_in = 8'h00;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  piso_shift_register_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid),
    .load_ready(load_ready), .data_in(data_in), .ser_out(ser_out),
    .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, ser_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sout"}, ser_out, 1'b0);
    chk({tag, "_rdy"}, load_ready, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  task automatic accept_word(input logic [7:0] w);
    load_valid = 1'b1;
    data_in    = w;
    tick();
    load_valid = 1'b0;
    data_in    = ~w;
  endtask

  initial begin
    logic [7:0]  w;
    logic [10:0] en_v;
    logic [10:0] s_v;

    // Reset state
    #12;
    chk_idle("rst");
    rst_n = 1'b1;
    tick();
    chk_idle("post_rst");

    // 1: A5 with en held high
    en = 1'b1;
    w  = 8'hA5;
    accept_word(w);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t1_sout", ser_out, w[7-i]);
      chk("t1_valid", ser_valid, 1'b1);
      chk("t1_done", done, i == 7);
      chk("t1_rdy", load_ready, i == 7);
      tick();
    end
    chk_idle("t1_end");

    // 2: back-to-back FF then 00, gapless
    load_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    data_in    = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) load_valid = 1'b0;
      #1;
      chk("t2_sout", ser_out, i < 8);
      chk("t2_valid", ser_valid, 1'b1);
      chk("t2_rdy", load_ready, i == 7 || i == 15);
      chk("t2_done", done, i == 7 || i == 15);
      tick();
    end
    chk_idle("t2_end");

    // 3: en dropped for 3 cycles while the 3rd bit is shown
    en_v = 11'b111111_00011;
    s_v  = 11'b10100111101;
    accept_word(8'hA5);
    for (int i = 0; i < 11; i++) begin
      en = en_v[i];
      #1;
      chk("t3_sout", ser_out, s_v[i]);
      chk("t3_busy", busy, 1'b1);
      chk("t3_done", done, i == 10);
      tick();
    end
    en = 1'b1;
    chk_idle("t3_end");

    // 4: load attempt mid-frame is ignored
    w = 8'hA5;
    accept_word(w);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        load_valid = 1'b1;
        data_in    = 8'h3C;
      end
      if (i == 4) load_valid = 1'b0;
      #1;
      chk("t4_sout", ser_out, w[7-i]);
      if (i == 3) chk("t4_rdy", load_ready, 1'b0);
      chk("t4_done", done, i == 7);
      tick();
    end
    chk_idle("t4_end");

    // 5: async reset during bit 5
    accept_word(8'hFF);
    repeat (4) tick();
    #1;
    chk("t5_pre_valid", ser_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_idle("t5_rst");
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("t5_after");
    end
    w = 8'h81;
    accept_word(w);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t5_sout", ser_out, w[7-i]);
      chk("t5_done", done, i == 7);
      tick();
    end
    chk_idle("t5_end");

`ifdef PARITY_EN
    // 6: parity trailer
    w = 8'h07;
    accept_word(w);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t6_sout", ser_out, (i < 8) ? w[7-i] : 1'b1);
      chk("t6_valid", ser_valid, 1'b1);
      chk("t6_done", done, i == 8);
      tick();
    end
    chk_idle("t6_end");
    w = 8'h03;
    accept_word(w);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("t6b_sout", ser_out, (i < 8) ? w[7-i] : 1'b0);
      chk("t6b_done", done, i == 8);
      tick();
    end
    chk_idle("t6b_end");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
